// File: rtl/uart_tx.sv
// UART transmitter fed by a first-word-fall-through FIFO: start, DATA_SIZE bits LSB first, stop.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_tx #(
   parameter int DATA_SIZE = 8,
   parameter int DVSR      = 434
) (
   input  logic                 ckht,
   input  logic                 rst,
   input  logic                 fifo_empty,
   input  logic [DATA_SIZE-1:0] fifo_data,
   output logic                 fifo_rd,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done_tick
);

   localparam int CNT_W = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int BIT_W = $clog2(DATA_SIZE) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVSR - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_SIZE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [BIT_W-1:0]     bit_idx;
   logic [DATA_SIZE-1:0] shreg;
`ifdef UART_TX_PARITY_EN
   logic                 par_bit;
`endif

   // The pop must coincide with the capture cycle of a FWFT FIFO, so fifo_rd is
   // decoded from the registered state rather than registered itself.
   assign fifo_rd      = (state == IDLE) && !fifo_empty && !rst;
   assign busy         = (state != IDLE);
   assign tx_done_tick = (state == STOP) && (cnt == CNT_LAST);

   // NOTE: all state is updated with non-blocking assignments so every branch
   // reads the pre-edge values of cnt/shreg, independent of statement order.
   always_ff @(posedge ckht or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tx      <= 1'b1;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
`ifdef UART_TX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  shreg   <= fifo_data;
`ifdef UART_TX_PARITY_EN
                  par_bit <= ^fifo_data;
`endif
                  cnt     <= '0;
                  bit_idx <= '0;
                  tx      <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
                  state <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (bit_idx == BIT_LAST) begin
                     bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     tx      <= par_bit;
                     state   <= PARITY;
`else
                     tx      <= 1'b1;
                     state   <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  tx    <= 1'b1;
                  state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx (DVSR=4, DATA_SIZE=8): stimulus queues FIFO words and expected
// frames; a negedge monitor pops an expectation on every fifo_rd and checks the serial waveform.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int DS = 8;
   localparam int DV = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME  = DV * (DS + 3);
   localparam bit PAR_ON = 1'b1;
`else
   localparam int FRAME  = DV * (DS + 2);
   localparam bit PAR_ON = 1'b0;
`endif

   logic          ckht = 1'b0;
   logic          rst = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DS-1:0] fifo_data = '0;
   logic          fifo_rd;
   logic          tx;
   logic          busy;
   logic          tx_done_tick;

   always #5 ckht = ~ckht;

   uart_tx #(.DATA_SIZE(DS), .DVSR(DV)) dut (
      .ckht         (ckht),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
      .fifo_rd      (fifo_rd),
      .tx           (tx),
      .busy         (busy),
      .tx_done_tick (tx_done_tick)
   );

   // bits: data bits in transmission order, first-sent bit in bit 7
   typedef struct {
      logic [7:0] bits;
      logic       par;
      int         gap;
   } exp_t;

   exp_t          sb[$];
   logic [DS-1:0] fifo_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            k = 0;
   int            last_rd = 0;
   bit            in_frame = 1'b0;
   bit            scramble = 1'b0;
   bit            do_pop = 1'b0;
   logic [DS-1:0] junk = 8'hA5;
   exp_t          cur;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
      end
   endtask

   function automatic logic exp_tx(input exp_t e, input int kk);
      int idx;
      if (kk <= DV) return 1'b0;
      if (kk <= DV * (DS + 1)) begin
         idx = DS - 1 - ((kk - DV - 1) / DV);
         return e.bits[idx];
      end
      if (PAR_ON && kk <= DV * (DS + 2)) return e.par;
      return 1'b1;
   endfunction

   // FIFO model: pop decided from fifo_rd seen mid-cycle, applied just after the edge
   always begin
      @(negedge ckht);
      do_pop = fifo_rd;
      @(posedge ckht);
      #1;
      if (do_pop) begin
         check("pop_nonempty", 32'(fifo_q.size() != 0), 1);
         if (fifo_q.size() != 0) fifo_q.delete(0);
      end
      if (scramble) junk = ~junk;
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = scramble ? junk : ((fifo_q.size() != 0) ? fifo_q[0] : '0);
   end

   // Monitor
   always @(negedge ckht) begin
      cyc++;
      if (fifo_rd) begin
         check("rd_while_empty", fifo_empty, 0);
         check("rd_outside_idle", busy, 0);
      end
      if (rst) begin
         in_frame = 1'b0;
      end else if (!in_frame) begin
         if (fifo_rd) begin
            check("expected_frame_pending", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               cur = sb.pop_front();
               if (cur.gap != 0) check("pop_gap", cyc - last_rd, cur.gap);
               last_rd  = cyc;
               in_frame = 1'b1;
               k        = 0;
            end
         end else begin
            check("idle_tx", tx, 1);
            check("idle_busy", busy, 0);
            check("idle_done", tx_done_tick, 0);
         end
      end else begin
         k++;
         check("tx_bit", tx, exp_tx(cur, k));
         check("frame_busy", busy, 1);
         check("done_tick", tx_done_tick, 32'(k == FRAME));
         if (k == FRAME) in_frame = 1'b0;
      end
   end

   task automatic send(input logic [DS-1:0] d, input logic [7:0] bits, input logic par,
                       input int gap);
      exp_t e;
      e.bits = bits;
      e.par  = par;
      e.gap  = gap;
      fifo_q.push_back(d);
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge ckht);
         #1;
         if (sb.size() == 0 && fifo_q.size() == 0 && !in_frame) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_idle_timeout", ok, 1);
   endtask

   task automatic wait_frame_start();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge ckht);
         #1;
         if (in_frame) begin
            ok = 1'b1;
            break;
         end
      end
      check("frame_start_timeout", ok, 1);
   endtask

   initial begin
      #2 rst = 1'b1;
      #1;
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_fifo_rd", fifo_rd, 0);
      check("reset_done", tx_done_tick, 0);
      repeat (3) @(negedge ckht);
      #2 rst = 1'b0;

      // long idle with an empty FIFO
      repeat (100) @(negedge ckht);

      send(8'h55, 8'b10101010, 1'b0, 0);
      wait_idle();

      // back-to-back frames: one idle-high cycle between them
      send(8'h55, 8'b10101010, 1'b0, 0);
      send(8'hA3, 8'b11000101, 1'b0, FRAME + 1);
      send(8'h07, 8'b11100000, 1'b1, FRAME + 1);
      wait_idle();

      // head word toggling during the frame must not leak into it
      send(8'h3C, 8'b00111100, 1'b0, 0);
      wait_frame_start();
      scramble = 1'b1;
      wait_idle();
      scramble = 1'b0;

      // reset during data bit 3 of 0xF0 aborts the frame
      send(8'hF0, 8'b00001111, 1'b0, 0);
      wait_frame_start();
      repeat (18) @(negedge ckht);
      check("pre_reset_busy", busy, 1);
      check("pre_reset_tx", tx, 0);
      #2 rst = 1'b1;
      #1;
      check("abort_tx", tx, 1);
      check("abort_busy", busy, 0);
      check("abort_fifo_rd", fifo_rd, 0);
      repeat (3) @(negedge ckht);
      #2 rst = 1'b0;
      repeat (30) @(negedge ckht);
      check("no_frame_after_reset", 32'(sb.size()), 0);
      check("no_pop_after_reset", 32'(in_frame), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
